// File: rtl/video_timing_gen.sv
// ============================================================================
//  video_timing_gen
//  Pixel timing (sync/blank/coords) and test-pattern generator for bring-up.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic [1:0]  pattern,
    output logic        hs,
    output logic        vs,
    output logic        hblank,
    output logic        vblank,
    output logic        de,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        frame_start,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b
);

    localparam int          c_h_total  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int          c_v_total  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [11:0] c_h_last   = 12'(c_h_total - 1);
    localparam logic [11:0] c_v_last   = 12'(c_v_total - 1);
    localparam logic [11:0] c_h_active = 12'(H_ACTIVE);
    localparam logic [11:0] c_v_active = 12'(V_ACTIVE);
    localparam logic [11:0] c_hs_start = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] c_hs_end   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] c_vs_start = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] c_vs_end   = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] c_bar_last = 12'(H_ACTIVE / 8 - 1);
    localparam logic        c_hs_on    = (HS_POL != 0);
    localparam logic        c_vs_on    = (VS_POL != 0);

    logic [11:0] hcnt_q, hcnt_d;
    logic [11:0] vcnt_q, vcnt_d;
    logic [11:0] bar_pix_q, bar_pix_d;
    logic [2:0]  bar_idx_q, bar_idx_d;
    logic [1:0]  pat_q, pat_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        hblank_q, hblank_d;
    logic        vblank_q, vblank_d;
    logic        de_q, de_d;
    logic        fs_q, fs_d;
    logic [11:0] xpos_q, xpos_d;
    logic [11:0] ypos_q, ypos_d;
    logic [23:0] rgb_q, rgb_d;

    logic        w_h_last;
    logic        w_v_last;
    logic        w_h_act;
    logic        w_v_act;
    logic        w_origin;
    logic        w_hs_win;
    logic        w_vs_win;
    logic [1:0]  w_pat;
    logic [23:0] w_rgb;

    assign w_h_last = (hcnt_q == c_h_last);
    assign w_v_last = (vcnt_q == c_v_last);
    assign w_h_act  = (hcnt_q < c_h_active);
    assign w_v_act  = (vcnt_q < c_v_active);
    assign w_origin = (hcnt_q == 12'd0) && (vcnt_q == 12'd0);
    assign w_hs_win = (hcnt_q >= c_hs_start) && (hcnt_q < c_hs_end);
    assign w_vs_win = (vcnt_q >= c_vs_start) && (vcnt_q < c_vs_end);
    // The pixel at the origin already uses the pattern being latched there.
    assign w_pat    = w_origin ? pattern : pat_q;

    always_comb begin
        w_rgb = 24'h000000;
        case (w_pat)
            2'd0: begin
                case (bar_idx_q)
                    3'd0:    w_rgb = 24'hFFFFFF;
                    3'd1:    w_rgb = 24'hFFFF00;
                    3'd2:    w_rgb = 24'h00FFFF;
                    3'd3:    w_rgb = 24'h00FF00;
                    3'd4:    w_rgb = 24'hFF00FF;
                    3'd5:    w_rgb = 24'hFF0000;
                    3'd6:    w_rgb = 24'h0000FF;
                    default: w_rgb = 24'h000000;
                endcase
            end
            2'd1:    w_rgb = (hcnt_q[5] ^ vcnt_q[5]) ? 24'h000000 : 24'hFFFFFF;
            2'd2:    w_rgb = {hcnt_q[7:0], vcnt_q[7:0], hcnt_q[7:0] ^ vcnt_q[7:0]};
            default: w_rgb = 24'h808080;
        endcase
    end

    always_comb begin
        hcnt_d    = hcnt_q;
        vcnt_d    = vcnt_q;
        bar_pix_d = bar_pix_q;
        bar_idx_d = bar_idx_q;
        pat_d     = pat_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        hblank_d  = hblank_q;
        vblank_d  = vblank_q;
        de_d      = de_q;
        fs_d      = 1'b0;
        xpos_d    = xpos_q;
        ypos_d    = ypos_q;
        rgb_d     = rgb_q;

        if (ce) begin
            hcnt_d = w_h_last ? 12'd0 : hcnt_q + 12'd1;
            if (w_h_last) begin
                vcnt_d = w_v_last ? 12'd0 : vcnt_q + 12'd1;
            end

            // Bar tracker follows hcnt so the bar index is valid for the next pixel.
            if (w_h_last) begin
                bar_pix_d = 12'd0;
                bar_idx_d = 3'd0;
            end else if (bar_pix_q == c_bar_last) begin
                bar_pix_d = 12'd0;
                bar_idx_d = (bar_idx_q == 3'd7) ? 3'd7 : bar_idx_q + 3'd1;
            end else begin
                bar_pix_d = bar_pix_q + 12'd1;
            end

            if (w_origin) begin
                pat_d = pattern;
            end

            hs_d     = w_hs_win ? c_hs_on : ~c_hs_on;
            vs_d     = w_vs_win ? c_vs_on : ~c_vs_on;
            hblank_d = ~w_h_act;
            vblank_d = ~w_v_act;
            de_d     = w_h_act & w_v_act;
            fs_d     = w_origin;
            xpos_d   = w_h_act ? hcnt_q : 12'd0;
            ypos_d   = w_v_act ? vcnt_q : 12'd0;
            rgb_d    = (w_h_act & w_v_act) ? w_rgb : 24'h000000;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt_q    <= 12'd0;
            vcnt_q    <= 12'd0;
            bar_pix_q <= 12'd0;
            bar_idx_q <= 3'd0;
            pat_q     <= 2'd0;
            hs_q      <= ~c_hs_on;
            vs_q      <= ~c_vs_on;
            hblank_q  <= 1'b1;
            vblank_q  <= 1'b1;
            de_q      <= 1'b0;
            fs_q      <= 1'b0;
            xpos_q    <= 12'd0;
            ypos_q    <= 12'd0;
            rgb_q     <= 24'h000000;
        end else begin
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            bar_pix_q <= bar_pix_d;
            bar_idx_q <= bar_idx_d;
            pat_q     <= pat_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            hblank_q  <= hblank_d;
            vblank_q  <= vblank_d;
            de_q      <= de_d;
            fs_q      <= fs_d;
            xpos_q    <= xpos_d;
            ypos_q    <= ypos_d;
            rgb_q     <= rgb_d;
        end
    end

    assign hs          = hs_q;
    assign vs          = vs_q;
    assign hblank      = hblank_q;
    assign vblank      = vblank_q;
    assign de          = de_q;
    assign frame_start = fs_q;
    assign xpos        = xpos_q;
    assign ypos        = ypos_q;
    assign r           = rgb_q[23:16];
    assign g           = rgb_q[15:8];
    assign b           = rgb_q[7:0];

endmodule

`default_nettype wire

// File: tb/tb_video_timing_gen.sv
// ============================================================================
//  tb_video_timing_gen
//  Self-checking bench: reference model works on a linear pixel index.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_video_timing_gen;

    localparam int HA = 68;
    localparam int HF = 4;
    localparam int HSY = 8;
    localparam int HB = 4;
    localparam int VA = 48;
    localparam int VF = 2;
    localparam int VSY = 3;
    localparam int VB = 3;
    localparam int HT = HA + HF + HSY + HB;
    localparam int VT = VA + VF + VSY + VB;
    localparam int FR = HT * VT;
    localparam int BW = HA / 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b0;
    logic [1:0]  pattern = 2'd0;
    logic        hs, vs, hblank, vblank, de, frame_start;
    logic [11:0] xpos, ypos;
    logic [7:0]  r, g, b;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .HS_POL(0), .VS_POL(0)
    ) dut (
        .clk(clk), .reset(reset), .ce(ce), .pattern(pattern),
        .hs(hs), .vs(vs), .hblank(hblank), .vblank(vblank), .de(de),
        .xpos(xpos), .ypos(ypos), .frame_start(frame_start),
        .r(r), .g(g), .b(b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int nprint = 0;

    // Model state: next pixel index to emit, last emitted position, latched pattern.
    int          m_idx = 0;
    int          m_oh = -1;
    int          m_ov = -1;
    int          m_pat = 0;
    logic [53:0] exp_vec = '0;
    logic [53:0] dut_vec;

    assign dut_vec = {hs, vs, hblank, vblank, de, frame_start, xpos, ypos, r, g, b};

    function automatic logic [23:0] bar_colour(input int i);
        case (i)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [53:0] expect_pixel(input int h, input int v, input int pat, input bit origin);
        logic        hb, vb, de_e, hs_e, vs_e;
        logic [11:0] x, y;
        logic [23:0] rgb;
        int          bar;
        hb   = (h >= HA);
        vb   = (v >= VA);
        de_e = !hb && !vb;
        hs_e = !(h >= HA + HF && h < HA + HF + HSY);
        vs_e = !(v >= VA + VF && v < VA + VF + VSY);
        x    = hb ? 12'd0 : 12'(h);
        y    = vb ? 12'd0 : 12'(v);
        rgb  = 24'h000000;
        if (de_e) begin
            case (pat)
                0: begin
                    bar = h / BW;
                    if (bar > 7) bar = 7;
                    rgb = bar_colour(bar);
                end
                1: rgb = (((h / 32) + (v / 32)) % 2 == 0) ? 24'hFFFFFF : 24'h000000;
                2: rgb = {8'(h % 256), 8'(v % 256), 8'((h ^ v) % 256)};
                default: rgb = 24'h808080;
            endcase
        end
        return {hs_e, vs_e, hb, vb, de_e, origin, x, y, rgb};
    endfunction

    task automatic tick(input logic rst_v, input logic ce_v, input logic [1:0] pat_v);
        int h, v;
        reset   = rst_v;
        ce      = ce_v;
        pattern = pat_v;
        @(posedge clk);
        #1;
        if (rst_v) begin
            m_idx   = 0;
            m_pat   = 0;
            m_oh    = -1;
            m_ov    = -1;
            exp_vec = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'd0, 12'd0, 24'd0};
        end else if (ce_v) begin
            h = m_idx % HT;
            v = m_idx / HT;
            if (m_idx == 0) m_pat = int'(pat_v);
            exp_vec = expect_pixel(h, v, m_pat, m_idx == 0);
            m_oh  = h;
            m_ov  = v;
            m_idx = (m_idx + 1) % FR;
        end else begin
            exp_vec[48] = 1'b0;
        end
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b1, 2'd2);
        tick(1'b1, 1'b0, 2'd1);
        checks++;
        if (dut_vec !== exp_vec) begin
            failures++;
            $display("FAIL reset_state actual=%h required=%h", dut_vec, exp_vec);
        end
    endtask

    task automatic test_timing();
        int last_fs = -1, last_hf = -1, last_vf = -1;
        logic prev_hs = 1'b1, prev_vs = 1'b1;
        tick(1'b1, 1'b0, 2'd0);
        for (int cyc = 0; cyc < 2 * FR + 20; cyc++) begin
            tick(1'b0, 1'b1, 2'd0);
            checks++;
            if (dut_vec !== exp_vec) begin
                failures++;
                if (nprint++ < 20) $display("FAIL timing_px cyc=%0d actual=%h required=%h", cyc, dut_vec, exp_vec);
            end
            if (m_oh == 7 && m_ov == 0) begin
                checks++;
                if ({r, g, b} !== 24'hFFFFFF) begin
                    failures++;
                    $display("FAIL bar0_edge actual=%h required=FFFFFF", {r, g, b});
                end
            end
            if (m_oh == 8 && m_ov == 0) begin
                checks++;
                if ({r, g, b} !== 24'hFFFF00) begin
                    failures++;
                    $display("FAIL bar1_start actual=%h required=FFFF00", {r, g, b});
                end
            end
            if (m_oh == HA - 1 && m_ov == 5) begin
                checks++;
                if ({r, g, b} !== 24'h000000) begin
                    failures++;
                    $display("FAIL bar_saturate actual=%h required=000000", {r, g, b});
                end
            end
            if (frame_start) begin
                if (last_fs >= 0) begin
                    checks++;
                    if (cyc - last_fs != FR) begin
                        failures++;
                        $display("FAIL fs_period actual=%0d required=%0d", cyc - last_fs, FR);
                    end
                end
                last_fs = cyc;
            end
            if (prev_hs && !hs) begin
                if (last_hf >= 0) begin
                    checks++;
                    if (cyc - last_hf != HT) begin
                        failures++;
                        $display("FAIL hs_period actual=%0d required=%0d", cyc - last_hf, HT);
                    end
                end
                last_hf = cyc;
            end
            if (!prev_hs && hs && last_hf >= 0) begin
                checks++;
                if (cyc - last_hf != HSY) begin
                    failures++;
                    $display("FAIL hs_width actual=%0d required=%0d", cyc - last_hf, HSY);
                end
            end
            if (prev_vs && !vs) last_vf = cyc;
            if (!prev_vs && vs && last_vf >= 0) begin
                checks++;
                if (cyc - last_vf != VSY * HT) begin
                    failures++;
                    $display("FAIL vs_width actual=%0d required=%0d", cyc - last_vf, VSY * HT);
                end
            end
            prev_hs = hs;
            prev_vs = vs;
        end
    endtask

    task automatic test_patterns();
        for (int p = 1; p < 4; p++) begin
            tick(1'b1, 1'b0, 2'(p));
            for (int cyc = 0; cyc < FR + 4; cyc++) begin
                tick(1'b0, 1'b1, 2'(p));
                checks++;
                if (dut_vec !== exp_vec) begin
                    failures++;
                    if (nprint++ < 20) $display("FAIL pattern%0d_px cyc=%0d actual=%h required=%h", p, cyc, dut_vec, exp_vec);
                end
                if (p == 1 && m_ov == 0 && (m_oh == 31 || m_oh == 32)) begin
                    checks++;
                    if ({r, g, b} !== ((m_oh == 31) ? 24'hFFFFFF : 24'h000000)) begin
                        failures++;
                        $display("FAIL checker_x%0d actual=%h", m_oh, {r, g, b});
                    end
                end
                if (p == 1 && m_ov == 32 && m_oh == 32) begin
                    checks++;
                    if ({r, g, b} !== 24'hFFFFFF) begin
                        failures++;
                        $display("FAIL checker_32_32 actual=%h required=FFFFFF", {r, g, b});
                    end
                end
                if (p == 2 && m_ov == 40 && m_oh == 60) begin
                    checks++;
                    if ({r, g, b} !== 24'h3C2814) begin
                        failures++;
                        $display("FAIL gradient_60_40 actual=%h required=3C2814", {r, g, b});
                    end
                end
                if (p == 3 && m_ov == 10 && m_oh == 10) begin
                    checks++;
                    if ({r, g, b} !== 24'h808080) begin
                        failures++;
                        $display("FAIL grey actual=%h required=808080", {r, g, b});
                    end
                end
            end
        end
    endtask

    task automatic test_pattern_change();
        logic [1:0] p = 2'd0;
        bit seen_new = 0;
        int after = 0;
        tick(1'b1, 1'b0, 2'd0);
        for (int cyc = 0; cyc < 2 * FR && after < 200; cyc++) begin
            if (m_ov == 20) p = 2'd3;
            tick(1'b0, 1'b1, p);
            if (p == 2'd3 && exp_vec[48]) seen_new = 1;
            if (seen_new) after++;
            checks++;
            if (dut_vec !== exp_vec) begin
                failures++;
                if (nprint++ < 20) $display("FAIL pat_change_px cyc=%0d actual=%h required=%h", cyc, dut_vec, exp_vec);
            end
            if (!seen_new && m_ov == 25 && m_oh == 0) begin
                checks++;
                if ({r, g, b} !== 24'hFFFFFF) begin
                    failures++;
                    $display("FAIL pat_midframe actual=%h required=FFFFFF", {r, g, b});
                end
            end
            if (seen_new && m_ov == 0 && m_oh == 0) begin
                checks++;
                if ({r, g, b} !== 24'h808080) begin
                    failures++;
                    $display("FAIL pat_next_frame actual=%h required=808080", {r, g, b});
                end
            end
        end
        checks++;
        if (!seen_new || after < 200) begin
            failures++;
            $display("FAIL pat_change_timeout actual=%0d required=200", after);
        end
    endtask

    task automatic test_ce_random();
        logic [1:0] p = 2'd0;
        logic prev_fs = 1'b0;
        tick(1'b1, 1'b0, 2'd0);
        for (int cyc = 0; cyc < 26000; cyc++) begin
            if (cyc % 700 == 0) p = 2'($urandom_range(0, 3));
            tick(1'b0, ($urandom_range(0, 3) == 0), p);
            checks++;
            if (dut_vec !== exp_vec) begin
                failures++;
                if (nprint++ < 20) $display("FAIL ce_random_px cyc=%0d actual=%h required=%h", cyc, dut_vec, exp_vec);
            end
            if (frame_start) begin
                checks++;
                if (prev_fs) begin
                    failures++;
                    $display("FAIL fs_width actual=2+ required=1");
                end
            end
            prev_fs = frame_start;
        end
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        tick(1'b1, 1'b0, 2'd2);
        while (!(m_ov == 30 && m_oh == 10) && guard < 8 * FR) begin
            tick(1'b0, ($urandom_range(0, 3) == 0), 2'd2);
            guard++;
        end
        checks++;
        if (guard >= 8 * FR) begin
            failures++;
            $display("FAIL reset_mid_timeout actual=%0d required<%0d", guard, 8 * FR);
        end
        tick(1'b1, 1'b1, 2'd1);
        checks++;
        if (hs !== 1'b1 || vs !== 1'b1 || de !== 1'b0 || dut_vec !== exp_vec) begin
            failures++;
            $display("FAIL reset_mid_state actual=%h required=%h", dut_vec, exp_vec);
        end
        tick(1'b0, 1'b0, 2'd1);
        checks++;
        if (dut_vec !== exp_vec) begin
            failures++;
            $display("FAIL reset_mid_hold actual=%h required=%h", dut_vec, exp_vec);
        end
        tick(1'b0, 1'b1, 2'd1);
        checks++;
        if (frame_start !== 1'b1 || xpos !== 12'd0 || ypos !== 12'd0 || de !== 1'b1 || dut_vec !== exp_vec) begin
            failures++;
            $display("FAIL reset_mid_origin actual=%h required=%h", dut_vec, exp_vec);
        end
        for (int cyc = 0; cyc < 3 * HT; cyc++) begin
            tick(1'b0, 1'b1, 2'd1);
            checks++;
            if (dut_vec !== exp_vec) begin
                failures++;
                if (nprint++ < 20) $display("FAIL reset_mid_px cyc=%0d actual=%h required=%h", cyc, dut_vec, exp_vec);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_timing();
        test_patterns();
        test_pattern_change();
        test_ce_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
